voice_alloc: RTL and testbench
==============================

Name: voice_alloc

Overview:
- Polyphonic voice allocator between the MIDI decoder and the oscillator stack.
- Consumes decoded note-on/note-off strobes with a note number and assigns each note to one oscillator voice.
- Tracks the note held by each voice and its age. Steals the oldest voice when all voices are busy.
- Drives per-voice one-hot select, note and on/off strobes. Replaces channel-indexed voice selection.

Parameters:
- VOICES, 7 (`OSC_VOICES), number of oscillator voices.
- NOTE_BW, 7 (`MIDI_PAYLOAD_BITS), note number width.
- RANK_BW, $clog2(VOICES), width of per-voice age rank.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- note_i  in  NOTE_BW  note number, valid with either strobe
- noteOnStrb_i  in  1  one-cycle note-on request
- noteOffStrb_i  in  1  one-cycle note-off request
- voiceSel_o  out  VOICES  one-hot target voice, registered
- voiceNote_o  out  NOTE_BW  note for target voice, registered
- voiceOnStrb_o  out  1  one-cycle start strobe for voiceSel_o
- voiceOffStrb_o  out  1  one-cycle stop strobe for voiceSel_o
- active_o  out  VOICES  per-voice allocated flag
- busy_o  out  1  high when FSM is not IDLE
- stolen_o  out  1  one-cycle pulse when a voice is stolen
- drop_o  out  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset (synchronous, rst_i=1): every output 0; all active bits, notes and ranks 0; skid buffer empty; FSM to IDLE. Reset mid-operation aborts the event with no further strobes.
- Per-voice state:
  - active bit, note, rank. Rank 0 is the newest.
  - Ranks are unique among active voices, 0..count-1.
  - On allocate/retrigger of voice v (old rank r, or count if newly allocated): all active voices with rank < r increment; v gets rank 0.
  - On release of voice v with rank r: active voices with rank > r decrement.
- Capture:
  - In IDLE, a strobe is latched into the event register (type, note) at edge N.
  - In any other state, a strobe goes to a 1-entry skid buffer. If the skid is full, it is discarded and drop_o pulses the next cycle.
  - noteOn and noteOff in the same cycle: off kept, on discarded, drop_o pulses.
- FSM states: IDLE, LOOKUP, STEAL_OFF, ISSUE_ON, ISSUE_OFF.
- LOOKUP (cycle N+1), search via voice_find:
  - NoteOn, note already active in voice m: target m, go to ISSUE_ON (retrigger).
  - NoteOn, free voice exists: target the lowest-index free voice, go to ISSUE_ON.
  - NoteOn, all voices active: target the voice with rank VOICES-1, go to STEAL_OFF.
  - NoteOff, match in voice m: target m, go to ISSUE_OFF.
  - NoteOff, no match: ignored, no strobe, go to next-state rule.
- STEAL_OFF (N+2): voiceOffStrb_o=1 and stolen_o=1 for the target voice; go to ISSUE_ON.
- ISSUE_ON (N+2, or N+3 after steal): voiceOnStrb_o=1; update the target's active bit, note and rank.
- ISSUE_OFF (N+2): voiceOffStrb_o=1; clear the target's active bit and update ranks.
- Next state after ISSUE_* or an ignored off: LOOKUP if the skid is valid (skid moves to the event register), else IDLE.
- Latency from strobe: 2 cycles normal, 3 cycles on steal.
- Output timing: voiceSel_o and voiceNote_o are valid in every strobe cycle and hold until the next target. active_o reflects the state after the update edge.

Decomposition:
- Shared constants: reuse `OSC_VOICES and `MIDI_PAYLOAD_BITS from global.v; add `VOICE_RANK_BW there.
- FSM state encoding: localparams.
- Sub-module voice_find, combinational. Inputs: active vector, notes, ranks, key. Outputs: match found/index, first-free found/index, oldest index.

Test Plan:
- Reset, then noteOn note 60 at edge N -> voiceOnStrb_o at N+2; voiceSel_o=7'b0000001; voiceNote_o=60; active_o=7'b0000001.
- NoteOn 60,62,64 spaced 4 cycles, then noteOff 62 -> off strobe with voiceSel_o=7'b0000010; active_o=7'b0000101. Next noteOn 65 -> voice 1.
- Seven noteOns 60..66, then noteOn 67 -> N+2: voiceOffStrb_o and stolen_o with sel=7'b0000001; N+3: voiceOnStrb_o, note 67, voice 0. A further noteOn 68 steals voice 1.
- NoteOn 60 twice (retrigger) -> second event gives an on strobe to voice 0 only; active_o stays 7'b0000001. NoteOff 61 (unheld) -> no strobe; busy_o drops after 1 LOOKUP cycle.
- NoteOn 60, 61, 62 on consecutive cycles -> 60 and 61 served in order (61 from skid); 62 discarded with drop_o=1. Same-cycle on+off -> off served, drop_o=1.
- rst_i asserted in STEAL_OFF -> no ISSUE_ON strobe; all outputs 0 next cycle; a subsequent noteOn 70 goes to voice 0.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// Shared constants and FSM encoding for the polyphonic voice allocator.
package voice_alloc_pkg;

  localparam int OSC_VOICES        = 7;
  localparam int MIDI_PAYLOAD_BITS = 7;
  localparam int VOICE_RANK_BW     = $clog2(OSC_VOICES);

  localparam logic [2:0] ST_IDLE      = 3'd0,
                         ST_LOOKUP    = 3'd1,
                         ST_STEAL_OFF = 3'd2,
                         ST_ISSUE_ON  = 3'd3,
                         ST_ISSUE_OFF = 3'd4;

endpackage

// File: rtl/voice_alloc_find.sv
// Combinational voice search: note match, lowest free voice, oldest active voice.
module voice_find
  import voice_alloc_pkg::*;
#(
  parameter int VOICES  = OSC_VOICES,
  parameter int NOTE_BW = MIDI_PAYLOAD_BITS,
  parameter int RANK_BW = VOICE_RANK_BW
) (
  input  logic [VOICES-1:0]         active,
  input  logic [VOICES*NOTE_BW-1:0] notes,
  input  logic [VOICES*RANK_BW-1:0] ranks,
  input  logic [NOTE_BW-1:0]        key,
  output logic                      match_found,
  output logic [RANK_BW-1:0]        match_idx,
  output logic                      free_found,
  output logic [RANK_BW-1:0]        free_idx,
  output logic [RANK_BW-1:0]        oldest_idx
);

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    oldest_idx  = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (active[i] && notes[i*NOTE_BW +: NOTE_BW] == key) begin
        match_found = 1'b1;
        match_idx   = RANK_BW'(i);
      end
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = RANK_BW'(i);
      end
      if (active[i] && ranks[i*RANK_BW +: RANK_BW] == RANK_BW'(VOICES - 1)) begin
        oldest_idx = RANK_BW'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note on/off strobes onto oscillator voices,
// retriggering held notes and stealing the oldest voice when all are busy.
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int VOICES  = OSC_VOICES,
  parameter int NOTE_BW = MIDI_PAYLOAD_BITS,
  parameter int RANK_BW = VOICE_RANK_BW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NOTE_BW-1:0] note_i,
  input  logic               noteOnStrb_i,
  input  logic               noteOffStrb_i,
  output logic [VOICES-1:0]  voiceSel_o,
  output logic [NOTE_BW-1:0] voiceNote_o,
  output logic               voiceOnStrb_o,
  output logic               voiceOffStrb_o,
  output logic [VOICES-1:0]  active_o,
  output logic               busy_o,
  output logic               stolen_o,
  output logic               drop_o
);

  logic [2:0]               state_q, state_d;
  logic                     ev_on_q, skid_v_q, skid_on_q;
  logic [NOTE_BW-1:0]       ev_note_q, skid_note_q;
  logic [VOICES-1:0]        act_q;
  logic [NOTE_BW-1:0]       note_q [VOICES];
  logic [RANK_BW-1:0]       rank_q [VOICES];
  logic [VOICES*NOTE_BW-1:0] notes_flat;
  logic [VOICES*RANK_BW-1:0] ranks_flat;
  logic                     match_found, free_found;
  logic [RANK_BW-1:0]       match_idx, free_idx, oldest_idx;
  logic [RANK_BW-1:0]       tgt_q, tgt_d, upd_idx;
  logic [RANK_BW:0]         count, old_rank;
  logic                     in_any, in_on, done, upd_on, upd_off, load_ev, drop_d;

  // Simultaneous on+off keeps the off; the lost on is reported via drop_o.
  assign in_any   = noteOnStrb_i | noteOffStrb_i;
  assign in_on    = noteOnStrb_i & ~noteOffStrb_i;
  assign active_o = act_q;

  always_comb begin
    notes_flat = '0;
    ranks_flat = '0;
    count      = '0;
    for (int i = 0; i < VOICES; i++) begin
      notes_flat[i*NOTE_BW +: NOTE_BW] = note_q[i];
      ranks_flat[i*RANK_BW +: RANK_BW] = rank_q[i];
      count = count + (RANK_BW+1)'(act_q[i]);
    end
  end

  voice_find #(.VOICES(VOICES), .NOTE_BW(NOTE_BW), .RANK_BW(RANK_BW)) u_find (
    .active      (act_q),
    .notes       (notes_flat),
    .ranks       (ranks_flat),
    .key         (ev_note_q),
    .match_found (match_found),
    .match_idx   (match_idx),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .oldest_idx  (oldest_idx)
  );

  // Next-state logic; 'done' marks the last cycle of an event.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tgt_d   = match_idx;
    if (ev_on_q && !match_found) tgt_d = free_found ? free_idx : oldest_idx;
    case (state_q)
      ST_IDLE:      if (in_any) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (ev_on_q) state_d = (match_found || free_found) ? ST_ISSUE_ON : ST_STEAL_OFF;
        else if (match_found) state_d = ST_ISSUE_OFF;
        else done = 1'b1;
      end
      ST_STEAL_OFF: state_d = ST_ISSUE_ON;
      ST_ISSUE_ON, ST_ISSUE_OFF: done = 1'b1;
      default:      state_d = ST_IDLE;
    endcase
    if (done) state_d = (skid_v_q || in_any) ? ST_LOOKUP : ST_IDLE;
  end

  // Voice table is updated on the edge that enters the strobe state.
  always_comb begin
    upd_on   = (state_q == ST_LOOKUP && state_d == ST_ISSUE_ON) || state_q == ST_STEAL_OFF;
    upd_off  = state_q == ST_LOOKUP && state_d == ST_ISSUE_OFF;
    upd_idx  = (state_q == ST_STEAL_OFF) ? tgt_q : tgt_d;
    old_rank = act_q[upd_idx] ? {1'b0, rank_q[upd_idx]} : count;
    load_ev  = (state_q == ST_IDLE && in_any) || (done && (skid_v_q || in_any));
    drop_d   = (noteOnStrb_i & noteOffStrb_i) | ((state_q != ST_IDLE) & in_any & skid_v_q);
  end

  always_comb begin
    voiceOnStrb_o  = state_q == ST_ISSUE_ON;
    voiceOffStrb_o = state_q == ST_STEAL_OFF || state_q == ST_ISSUE_OFF;
    stolen_o       = state_q == ST_STEAL_OFF;
    busy_o         = state_q != ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_on_q   <= 1'b0;
      skid_note_q <= '0;
      tgt_q       <= '0;
      voiceSel_o  <= '0;
      voiceNote_o <= '0;
      drop_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_o  <= drop_d;
      if (load_ev) begin
        ev_on_q   <= skid_v_q ? skid_on_q : in_on;
        ev_note_q <= skid_v_q ? skid_note_q : note_i;
      end
      // A strobe arriving in an event's final cycle bypasses the skid.
      if (done && skid_v_q) begin
        skid_v_q <= 1'b0;
      end else if (state_q != ST_IDLE && in_any && !skid_v_q && !done) begin
        skid_v_q    <= 1'b1;
        skid_on_q   <= in_on;
        skid_note_q <= note_i;
      end
      if (state_q == ST_LOOKUP && state_d != ST_IDLE && state_d != ST_LOOKUP) begin
        tgt_q       <= tgt_d;
        voiceSel_o  <= {{(VOICES-1){1'b0}}, 1'b1} << tgt_d;
        voiceNote_o <= (state_d == ST_STEAL_OFF) ? note_q[tgt_d] : ev_note_q;
      end else if (state_q == ST_STEAL_OFF) begin
        voiceNote_o <= ev_note_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (upd_on) begin
          if (RANK_BW'(i) == upd_idx) begin
            act_q[i]  <= 1'b1;
            note_q[i] <= ev_note_q;
            rank_q[i] <= '0;
          end else if (act_q[i] && {1'b0, rank_q[i]} < old_rank) begin
            rank_q[i] <= rank_q[i] + 1'b1;
          end
        end else if (upd_off) begin
          if (RANK_BW'(i) == upd_idx) begin
            act_q[i]  <= 1'b0;
            rank_q[i] <= '0;
          end else if (act_q[i] && {1'b0, rank_q[i]} > old_rank) begin
            rank_q[i] <= rank_q[i] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus random note traffic
// against an event-level model (age-ordered voice list, skid and timing arithmetic).
module tb_voice_alloc;

  localparam int NV   = 7;
  localparam int MAXC = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] note = '0;
  logic       on_s = 1'b0, off_s = 1'b0;
  logic [6:0] voiceSel_o, voiceNote_o, active_o;
  logic       voiceOnStrb_o, voiceOffStrb_o, busy_o, stolen_o, drop_o;

  voice_alloc dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .note_i         (note),
    .noteOnStrb_i   (on_s),
    .noteOffStrb_i  (off_s),
    .voiceSel_o     (voiceSel_o),
    .voiceNote_o    (voiceNote_o),
    .voiceOnStrb_o  (voiceOnStrb_o),
    .voiceOffStrb_o (voiceOffStrb_o),
    .active_o       (active_o),
    .busy_o         (busy_o),
    .stolen_o       (stolen_o),
    .drop_o         (drop_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit prev_rst = 1'b0;

  // Reference model: voice table, newest-first age list, skid, per-cycle expectations
  bit         m_act  [NV];
  logic [6:0] m_note [NV];
  int         age_q[$];
  int         cur_end = 0;
  bit         skid_v = 1'b0, skid_on = 1'b0;
  logic [6:0] skid_note = '0;
  bit         exp_drop [MAXC];
  bit         exp_busy [MAXC];
  bit         act_set  [MAXC];
  logic [6:0] act_val  [MAXC];
  logic [6:0] cur_act = '0;
  // Strobe record: {cycle[15:0], on, off, stolen, sel[6:0], note[6:0], active[6:0]}
  logic [39:0] exp_q[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] m_act_vec();
    logic [6:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic void age_remove(int v);
    for (int i = 0; i < age_q.size(); i++) begin
      if (age_q[i] == v) begin
        age_q.delete(i);
        break;
      end
    end
  endfunction

  function automatic void push_rec(int c, bit on, bit off, bit stl, int v, logic [6:0] n);
    logic [6:0] sel = 7'(1 << v);
    exp_q.push_back({16'(c), on, off, stl, sel, n, m_act_vec()});
  endfunction

  function automatic void set_act(int c);
    act_set[c] = 1'b1;
    act_val[c] = m_act_vec();
  endfunction

  // Serve one event latched at cycle s: update the voice table and schedule outputs.
  function automatic void start_ev(int s, bit is_on, logic [6:0] n);
    int v = -1;
    int d = 1;
    for (int i = NV - 1; i >= 0; i--) if (m_act[i] && m_note[i] == n) v = i;
    if (is_on) begin
      if (v >= 0) begin
        age_remove(v);
        age_q.push_front(v);
        d = 2;
        push_rec(s + 2, 1, 0, 0, v, n);
      end else begin
        for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) v = i;
        if (v >= 0) begin
          m_act[v] = 1'b1;
          m_note[v] = n;
          age_q.push_front(v);
          d = 2;
          push_rec(s + 2, 1, 0, 0, v, n);
          set_act(s + 2);
        end else begin
          v = age_q[age_q.size() - 1];
          push_rec(s + 2, 0, 1, 1, v, m_note[v]);
          m_note[v] = n;
          age_remove(v);
          age_q.push_front(v);
          d = 3;
          push_rec(s + 3, 1, 0, 0, v, n);
        end
      end
    end else if (v >= 0) begin
      m_act[v] = 1'b0;
      age_remove(v);
      d = 2;
      push_rec(s + 2, 0, 1, 0, v, n);
      set_act(s + 2);
    end
    for (int j = 1; j <= d; j++) exp_busy[s + j] = 1'b1;
    cur_end = s + d;
  endfunction

  function automatic void model_cycle(bit r, bit on, bit off, logic [6:0] n, int k);
    bit any = on | off;
    bit ev_on = on & ~off;
    logic [39:0] last;
    if (r) begin
      for (int j = k + 1; j < MAXC; j++) begin
        exp_busy[j] = 1'b0;
        exp_drop[j] = 1'b0;
        act_set[j]  = 1'b0;
      end
      act_set[k + 1] = 1'b1;
      act_val[k + 1] = '0;
      while (exp_q.size() > 0) begin
        last = exp_q[exp_q.size() - 1];
        if (int'(last[39:24]) > k) void'(exp_q.pop_back());
        else break;
      end
      for (int i = 0; i < NV; i++) begin
        m_act[i]  = 1'b0;
        m_note[i] = '0;
      end
      age_q.delete();
      skid_v  = 1'b0;
      cur_end = k;
      return;
    end
    if (on && off) exp_drop[k + 1] = 1'b1;
    if (k == cur_end && skid_v) begin
      if (any) exp_drop[k + 1] = 1'b1;
      skid_v = 1'b0;
      start_ev(k, skid_on, skid_note);
    end else if (any) begin
      if (k >= cur_end) start_ev(k, ev_on, n);
      else if (skid_v) exp_drop[k + 1] = 1'b1;
      else begin
        skid_v    = 1'b1;
        skid_on   = ev_on;
        skid_note = n;
      end
    end
  endfunction

  // Driver: one clock cycle of stimulus followed by scoreboard checks mid-cycle.
  task automatic step(bit r, bit on, bit off, logic [6:0] n);
    logic [23:0] obs;
    logic [39:0] e;
    @(posedge clk);
    #1;
    cyc++;
    rst   = r;
    on_s  = on;
    off_s = off;
    note  = n;
    model_cycle(r, on, off, n, cyc);
    @(negedge clk);
    check("drop", drop_o, exp_drop[cyc]);
    check("busy", busy_o, exp_busy[cyc]);
    if (act_set[cyc]) cur_act = act_val[cyc];
    check("active", active_o, cur_act);
    obs = {voiceOnStrb_o, voiceOffStrb_o, stolen_o, voiceSel_o, voiceNote_o, active_o};
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    if (exp_q.size() > 0 && int'(e[39:24]) == cyc) begin
      void'(exp_q.pop_front());
      check("strobe", obs, e[23:0]);
    end else begin
      check("no_strobe", {voiceOnStrb_o, voiceOffStrb_o, stolen_o}, 3'b000);
    end
    if (prev_rst) begin
      check("reset_sel", voiceSel_o, 7'd0);
      check("reset_note", voiceNote_o, 7'd0);
    end
    prev_rst = r;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    idle(1);
  endtask

  task automatic fill_all();
    for (int i = 0; i < NV; i++) begin
      step(0, 1, 0, 7'(60 + i));
      idle(3);
    end
  endtask

  initial begin
    do_reset();
    check("reset_active", active_o, 7'd0);
    check("reset_busy", busy_o, 1'b0);

    // First note lands on voice 0 two cycles after the strobe
    step(0, 1, 0, 7'd60);
    idle(2);
    check("first_on_strobe", voiceOnStrb_o, 1'b1);
    check("first_on_sel", voiceSel_o, 7'b0000001);
    check("first_on_note", voiceNote_o, 7'd60);
    check("first_on_active", active_o, 7'b0000001);
    idle(2);

    // Release of a middle voice, then reuse of the freed slot
    do_reset();
    step(0, 1, 0, 7'd60); idle(3);
    step(0, 1, 0, 7'd62); idle(3);
    step(0, 1, 0, 7'd64); idle(3);
    step(0, 0, 1, 7'd62); idle(2);
    check("off_strobe", voiceOffStrb_o, 1'b1);
    check("off_sel", voiceSel_o, 7'b0000010);
    check("off_active", active_o, 7'b0000101);
    idle(2);
    step(0, 1, 0, 7'd65); idle(2);
    check("reuse_sel", voiceSel_o, 7'b0000010);
    idle(2);

    // Steal the oldest voice twice
    do_reset();
    fill_all();
    step(0, 1, 0, 7'd67); idle(2);
    check("steal_off", {voiceOffStrb_o, stolen_o}, 2'b11);
    check("steal_sel", voiceSel_o, 7'b0000001);
    idle(1);
    check("steal_on", voiceOnStrb_o, 1'b1);
    check("steal_on_note", voiceNote_o, 7'd67);
    idle(2);
    step(0, 1, 0, 7'd68); idle(2);
    check("steal2_sel", voiceSel_o, 7'b0000010);
    idle(3);

    // Retrigger and unheld release
    do_reset();
    step(0, 1, 0, 7'd60); idle(3);
    step(0, 1, 0, 7'd60); idle(3);
    check("retrig_active", active_o, 7'b0000001);
    step(0, 0, 1, 7'd61); idle(1);
    check("unheld_busy", busy_o, 1'b1);
    idle(1);
    check("unheld_idle", busy_o, 1'b0);

    // Back-to-back strobes: skid then drop; simultaneous on+off
    do_reset();
    step(0, 1, 0, 7'd60);
    step(0, 1, 0, 7'd61);
    step(0, 1, 0, 7'd62);
    idle(1);
    check("skid_drop", drop_o, 1'b1);
    idle(6);
    step(0, 1, 1, 7'd61); idle(1);
    check("onoff_drop", drop_o, 1'b1);
    idle(4);

    // Reset during a steal aborts it
    do_reset();
    fill_all();
    step(0, 1, 0, 7'd72); idle(1);
    step(1, 0, 0, '0);
    idle(1);
    check("abort_on", voiceOnStrb_o, 1'b0);
    check("abort_active", active_o, 7'd0);
    step(0, 1, 0, 7'd70); idle(2);
    check("post_abort_sel", voiceSel_o, 7'b0000001);
    check("post_abort_note", voiceNote_o, 7'd70);
    idle(2);

    // Random traffic over a narrow note range to force matches and steals
    for (int i = 0; i < 2500; i++) begin
      int r = $urandom_range(0, 199);
      logic [6:0] n = 7'(60 + $urandom_range(0, 11));
      if (r == 0) step(1, 0, 0, '0);
      else if (r < 60) step(0, 1, 0, n);
      else if (r < 100) step(0, 0, 1, n);
      else if (r < 106) step(0, 1, 1, n);
      else step(0, 0, 0, '0);
    end
    idle(8);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
